// File: rtl/xrv1_mem_arb_if.sv
// Bundle of the fetch, data and shared memory channels seen by xrv1_mem_arb.
// Names are from the arbiter's point of view; master is the arbiter, slave is its surroundings.
interface xrv1_mem_arb_if;
  logic        imem_req_vld_i;
  logic        imem_req_rdy_o;
  logic [31:0] imem_req_addr_i;
  logic        imem_resp_vld_o;
  logic [31:0] imem_resp_data_o;
  logic        imem_resp_err_o;

  logic        dmem_req_vld_i;
  logic        dmem_req_rdy_o;
  logic [31:0] dmem_req_addr_i;
  logic        dmem_req_w_en_i;
  logic [3:0]  dmem_req_w_be_i;
  logic [31:0] dmem_req_w_data_i;
  logic        dmem_resp_vld_o;
  logic [31:0] dmem_resp_r_data_o;
  logic        dmem_resp_err_o;

  logic        mem_req_vld_o;
  logic        mem_req_rdy_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_w_en_o;
  logic [3:0]  mem_req_w_be_o;
  logic [31:0] mem_req_w_data_o;
  logic        mem_resp_vld_i;
  logic [31:0] mem_resp_r_data_i;
  logic        mem_resp_err_i;

  logic        proto_err_o;
  logic        dbg_hold_o;
  logic        dbg_empty_o;

  modport master (
    input  imem_req_vld_i, imem_req_addr_i,
    input  dmem_req_vld_i, dmem_req_addr_i, dmem_req_w_en_i, dmem_req_w_be_i, dmem_req_w_data_i,
    input  mem_req_rdy_i, mem_resp_vld_i, mem_resp_r_data_i, mem_resp_err_i,
    output imem_req_rdy_o, imem_resp_vld_o, imem_resp_data_o, imem_resp_err_o,
    output dmem_req_rdy_o, dmem_resp_vld_o, dmem_resp_r_data_o, dmem_resp_err_o,
    output mem_req_vld_o, mem_req_addr_o, mem_req_w_en_o, mem_req_w_be_o, mem_req_w_data_o,
    output proto_err_o, dbg_hold_o, dbg_empty_o
  );

  modport slave (
    output imem_req_vld_i, imem_req_addr_i,
    output dmem_req_vld_i, dmem_req_addr_i, dmem_req_w_en_i, dmem_req_w_be_i, dmem_req_w_data_i,
    output mem_req_rdy_i, mem_resp_vld_i, mem_resp_r_data_i, mem_resp_err_i,
    input  imem_req_rdy_o, imem_resp_vld_o, imem_resp_data_o, imem_resp_err_o,
    input  dmem_req_rdy_o, dmem_resp_vld_o, dmem_resp_r_data_o, dmem_resp_err_o,
    input  mem_req_vld_o, mem_req_addr_o, mem_req_w_en_o, mem_req_w_be_o, mem_req_w_data_o,
    input  proto_err_o, dbg_hold_o, dbg_empty_o
  );
endinterface

// File: rtl/xrv1_mem_arb.sv
// Fetch/data arbiter for a single-ported TCM channel with grant hold, imem anti-starvation
// and an ID FIFO that steers in-order responses back to their requester.
module xrv1_mem_arb #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  xrv1_mem_arb_if.master bus
);
  // Handshake: a request transfers in the cycle where mem_req_vld_o & mem_req_rdy_i; the
  // requester sees *_req_rdy_o in that same cycle and must hold vld/payload stable until then.
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                     state_q;
  logic                       held_id_q;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_q, rd_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [STV_W-1:0]           starve_q, starve_d;
  logic                       perr_q;

  logic win_id, win_vld, full, empty, req_vld, accept, pop, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  // dmem has priority unless imem has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    win_id  = 1'b0;
    win_vld = 1'b0;
    if (state_q == HOLD) begin
      win_id  = held_id_q;
      win_vld = held_id_q ? bus.dmem_req_vld_i : bus.imem_req_vld_i;
    end else if (bus.dmem_req_vld_i &&
                 !(starve_q == STV_W'(STARVE_LIMIT) && bus.imem_req_vld_i)) begin
      win_id  = 1'b1;
      win_vld = 1'b1;
    end else if (bus.imem_req_vld_i) begin
      win_vld = 1'b1;
    end
  end

  assign req_vld = win_vld & ~full;
  assign accept  = req_vld & bus.mem_req_rdy_i;
  assign pop     = bus.mem_resp_vld_i & ~empty;
  assign head    = id_q[rd_q];

  assign bus.mem_req_vld_o    = req_vld;
  assign bus.mem_req_addr_o   = !req_vld ? '0 : (win_id ? bus.dmem_req_addr_i : bus.imem_req_addr_i);
  assign bus.mem_req_w_en_o   = req_vld & win_id & bus.dmem_req_w_en_i;
  assign bus.mem_req_w_be_o   = (req_vld && win_id) ? bus.dmem_req_w_be_i : '0;
  assign bus.mem_req_w_data_o = (req_vld && win_id) ? bus.dmem_req_w_data_i : '0;
  assign bus.imem_req_rdy_o   = accept & ~win_id;
  assign bus.dmem_req_rdy_o   = accept & win_id;

  assign bus.imem_resp_vld_o    = pop & ~head;
  assign bus.imem_resp_data_o   = (pop && !head) ? bus.mem_resp_r_data_i : '0;
  assign bus.imem_resp_err_o    = pop & ~head & bus.mem_resp_err_i;
  assign bus.dmem_resp_vld_o    = pop & head;
  assign bus.dmem_resp_r_data_o = (pop && head) ? bus.mem_resp_r_data_i : '0;
  assign bus.dmem_resp_err_o    = pop & head & bus.mem_resp_err_i;

  assign bus.proto_err_o = perr_q;
  assign bus.dbg_hold_o  = (state_q == HOLD);
  assign bus.dbg_empty_o = empty;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.imem_req_vld_i || bus.imem_req_rdy_o) starve_d = '0;
    else if (bus.dmem_req_rdy_o && starve_q != STV_W'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      held_id_q <= 1'b0;
      id_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_vld && !bus.mem_req_rdy_i) begin
          state_q   <= HOLD;
          held_id_q <= win_id;
        end
        HOLD: if (!win_vld || accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        id_q[wr_q] <= win_id;
        wr_q       <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      if (bus.mem_resp_vld_i && empty) perr_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xrv1_mem_arb.sv
// Directed cycle-by-cycle vectors for xrv1_mem_arb, plus hand sequences around reset.
module tb_xrv1_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xrv1_mem_arb_if bus();
  xrv1_mem_arb #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic ivld; logic [31:0] iaddr;
    logic dvld; logic [31:0] daddr; logic dwen; logic [3:0] dbe; logic [31:0] dwd;
    logic mrdy; logic rvld; logic [31:0] rdata; logic rerr;
  } in_t;

  typedef struct packed {
    logic mvld; logic [31:0] maddr; logic mwen; logic [3:0] mbe; logic [31:0] mwd;
    logic irdy; logic drdy;
    logic irvld; logic [31:0] irdata; logic ierr;
    logic drvld; logic [31:0] drdata; logic derr;
    logic perr;
  } out_t;

  typedef struct {
    in_t   stim;
    out_t  exp_o;
    string name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic in_t mk_in(logic ivld, logic [31:0] iaddr, logic dvld, logic [31:0] daddr,
                                logic dwen, logic [3:0] dbe, logic [31:0] dwd, logic mrdy,
                                logic rvld, logic [31:0] rdata, logic rerr);
    in_t r;
    r = '{ivld, iaddr, dvld, daddr, dwen, dbe, dwd, mrdy, rvld, rdata, rerr};
    return r;
  endfunction

  // err applies to whichever response port is expected valid.
  function automatic out_t mk_out(logic mvld, logic [31:0] maddr, logic mwen, logic [3:0] mbe,
                                  logic [31:0] mwd, logic irdy, logic drdy,
                                  logic irvld, logic [31:0] ird, logic drvld, logic [31:0] drd,
                                  logic err, logic perr);
    out_t r;
    r = '{mvld, maddr, mwen, mbe, mwd, irdy, drdy, irvld, ird, irvld & err,
          drvld, drd, drvld & err, perr};
    return r;
  endfunction

  function automatic vec_t mk_vec(string name, in_t s, out_t e);
    vec_t v;
    v.stim = s; v.exp_o = e; v.name = name;
    return v;
  endfunction

  function automatic out_t sample();
    out_t r;
    r = '{bus.mem_req_vld_o, bus.mem_req_addr_o, bus.mem_req_w_en_o, bus.mem_req_w_be_o,
          bus.mem_req_w_data_o, bus.imem_req_rdy_o, bus.dmem_req_rdy_o,
          bus.imem_resp_vld_o, bus.imem_resp_data_o, bus.imem_resp_err_o,
          bus.dmem_resp_vld_o, bus.dmem_resp_r_data_o, bus.dmem_resp_err_o, bus.proto_err_o};
    return r;
  endfunction

  task automatic drive(input in_t s);
    bus.imem_req_vld_i    = s.ivld;
    bus.imem_req_addr_i   = s.iaddr;
    bus.dmem_req_vld_i    = s.dvld;
    bus.dmem_req_addr_i   = s.daddr;
    bus.dmem_req_w_en_i   = s.dwen;
    bus.dmem_req_w_be_i   = s.dbe;
    bus.dmem_req_w_data_i = s.dwd;
    bus.mem_req_rdy_i     = s.mrdy;
    bus.mem_resp_vld_i    = s.rvld;
    bus.mem_resp_r_data_i = s.rdata;
    bus.mem_resp_err_i    = s.rerr;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
  task automatic apply(input vec_t v);
    out_t act;
    drive(v.stim);
    @(negedge clk);
    act = sample();
    n_vec++;
    if (act !== v.exp_o) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", v.name, act, v.exp_o);
    end
    @(posedge clk);
    #1;
  endtask

  in_t  idle_in;
  out_t zero_out;

  initial begin
    idle_in  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_out = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single fetch then its response
    vecs.push_back(mk_vec("A0 imem req", mk_in(1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("A1 imem resp", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'hDEADBEEF, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0)));
    // dmem wins four times, then imem is forced
    vecs.push_back(mk_vec("B0 dmem 1", mk_in(1, 'h104, 1, 'h200, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h200, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("B1 dmem 2", mk_in(1, 'h104, 1, 'h200, 0, 0, 0, 1, 1, 'h11, 0),
                          mk_out(1, 'h200, 0, 0, 0, 0, 1, 0, 0, 1, 'h11, 0, 0)));
    vecs.push_back(mk_vec("B2 dmem 3", mk_in(1, 'h104, 1, 'h200, 0, 0, 0, 1, 1, 'h12, 0),
                          mk_out(1, 'h200, 0, 0, 0, 0, 1, 0, 0, 1, 'h12, 0, 0)));
    vecs.push_back(mk_vec("B3 dmem 4", mk_in(1, 'h104, 1, 'h200, 0, 0, 0, 1, 1, 'h13, 0),
                          mk_out(1, 'h200, 0, 0, 0, 0, 1, 0, 0, 1, 'h13, 0, 0)));
    vecs.push_back(mk_vec("B4 imem forced", mk_in(1, 'h104, 1, 'h200, 0, 0, 0, 1, 1, 'h14, 0),
                          mk_out(1, 'h104, 0, 0, 0, 1, 0, 0, 0, 1, 'h14, 0, 0)));
    vecs.push_back(mk_vec("B5 starve cleared", mk_in(1, 'h104, 1, 'h200, 0, 0, 0, 1, 1, 'h15, 0),
                          mk_out(1, 'h200, 0, 0, 0, 0, 1, 1, 'h15, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("B6 dmem resp err", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h16, 1),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h16, 1, 0)));
    // held dmem write against a waiting imem
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk_vec($sformatf("C%0d dmem write held", i),
                            mk_in(1, 'h108, 1, 'h40, 1, 'hF, 'hCAFEF00D, 0, 0, 0, 0),
                            mk_out(1, 'h40, 1, 'hF, 'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("C3 dmem write accept", mk_in(1, 'h108, 1, 'h40, 1, 'hF, 'hCAFEF00D, 1, 0, 0, 0),
                          mk_out(1, 'h40, 1, 'hF, 'hCAFEF00D, 0, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("C4 imem after write", mk_in(1, 'h108, 0, 0, 0, 0, 0, 1, 1, 'h21, 0),
                          mk_out(1, 'h108, 0, 0, 0, 1, 0, 0, 0, 1, 'h21, 0, 0)));
    vecs.push_back(mk_vec("C5 imem resp", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h22, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h22, 0, 0, 0, 0)));
    // held imem grant is not stolen by a later dmem request
    vecs.push_back(mk_vec("D0 imem stalled", mk_in(1, 'h10C, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(1, 'h10C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("D1 imem kept", mk_in(1, 'h10C, 1, 'h300, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(1, 'h10C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("D2 imem accept", mk_in(1, 'h10C, 1, 'h300, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h10C, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("D3 dmem next", mk_in(0, 0, 1, 'h300, 0, 0, 0, 1, 1, 'h31, 0),
                          mk_out(1, 'h300, 0, 0, 0, 0, 1, 1, 'h31, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("D4 dmem resp", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h32, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h32, 0, 0)));
    // held requester drops vld
    vecs.push_back(mk_vec("E0 imem stalled", mk_in(1, 'h110, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                          mk_out(1, 'h110, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("E1 held imem dropped", mk_in(0, 0, 1, 'h304, 0, 0, 0, 0, 0, 0, 0),
                          zero_out));
    vecs.push_back(mk_vec("E2 dmem after drop", mk_in(0, 0, 1, 'h304, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h304, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("E3 dmem resp", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h41, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h41, 0, 0)));
    // FIFO full with responses withheld
    vecs.push_back(mk_vec("G0 imem accept", mk_in(1, 'h120, 0, 0, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h120, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("G1 dmem accept", mk_in(0, 0, 1, 'h400, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h400, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("G2 full blocks", mk_in(0, 0, 1, 'h404, 0, 0, 0, 1, 0, 0, 0), zero_out));
    vecs.push_back(mk_vec("G3 full pop no push", mk_in(0, 0, 1, 'h404, 0, 0, 0, 1, 1, 'h61, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h61, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("G4 accept after pop", mk_in(0, 0, 1, 'h404, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h404, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec("G5 dmem resp", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h62, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h62, 0, 0)));
    vecs.push_back(mk_vec("G6 dmem resp", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h63, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h63, 0, 0)));
    // stray response
    vecs.push_back(mk_vec("F0 stray resp", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h55, 1), zero_out));
    vecs.push_back(mk_vec("F1 proto_err set", idle_in,
                          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk_vec("F2 req with proto_err", mk_in(1, 'h130, 0, 0, 0, 0, 0, 1, 0, 0, 0),
                          mk_out(1, 'h130, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk_vec("F3 proto_err sticky", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h70, 0),
                          mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h70, 0, 0, 0, 1)));

    drive(idle_in);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    apply(mk_vec("reset outputs", idle_in, zero_out));
    check_bit("reset fifo empty", bus.dbg_empty_o, 1'b1);
    check_bit("reset not holding", bus.dbg_hold_o, 1'b0);

    foreach (vecs[i]) apply(vecs[i]);

    // two requests outstanding, then reset mid-transaction
    apply(mk_vec("R0 imem accept", mk_in(1, 'h140, 0, 0, 0, 0, 0, 1, 0, 0, 0),
                 mk_out(1, 'h140, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1)));
    apply(mk_vec("R1 dmem accept", mk_in(0, 0, 1, 'h500, 0, 0, 0, 1, 0, 0, 0),
                 mk_out(1, 'h500, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1)));
    check_bit("R1 fifo occupied", bus.dbg_empty_o, 1'b0);
    drive(idle_in);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    apply(mk_vec("R2 after reset", idle_in, zero_out));
    check_bit("R2 fifo empty", bus.dbg_empty_o, 1'b1);
    apply(mk_vec("R3 imem accept", mk_in(1, 'h150, 0, 0, 0, 0, 0, 1, 0, 0, 0),
                 mk_out(1, 'h150, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
    apply(mk_vec("R4 resp to imem", mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h80, 0),
                 mk_out(0, 0, 0, 0, 0, 0, 0, 1, 'h80, 0, 0, 0, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
